// File: rtl/bram_rr_arbiter_if.sv
// Requester-side and BRAM-side bus of the shared packet-buffer arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface bram_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            wr_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]            wr_gnt;
    logic [NUM_REQ-1:0]            rd_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_REQ-1:0]            rd_gnt;
    logic                          rd_valid;
    logic [ID_WIDTH-1:0]           rd_id;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          bram_we;
    logic [ADDR_WIDTH-1:0]         bram_waddr;
    logic [DATA_WIDTH-1:0]         bram_wdata;
    logic                          bram_re;
    logic [ADDR_WIDTH-1:0]         bram_raddr;
    logic [DATA_WIDTH-1:0]         bram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_rdata,
        output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
               bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_rdata,
        input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data,
               bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr
    );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one simple dual-port BRAM between NUM_REQ requesters.
// Optional write-first bypass on same-address collisions: BRAM_RR_ARBITER_WR_BYPASS_EN.
module bram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    bram_rr_arbiter_if.slave  bus
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int PW       = ID_WIDTH + 1;

    logic [ID_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [NUM_REQ-1:0]    wr_gnt_c, rd_gnt_c;
    logic [ID_WIDTH-1:0]   wr_idx, rd_idx;
    logic [ADDR_WIDTH-1:0] waddr_c, raddr_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  rd_valid_q;
    logic [ID_WIDTH-1:0]   rd_id_q;

    // First requester found walking up from ptr, wrapping mod NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [ID_WIDTH-1:0] ptr);
        logic [NUM_REQ-1:0] gnt;
        logic [PW-1:0]      pos;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + PW'(k);
            if (pos >= PW'(NUM_REQ))
                pos = pos - PW'(NUM_REQ);
            if (!found && req[pos[ID_WIDTH-1:0]]) begin
                gnt[pos[ID_WIDTH-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [ID_WIDTH-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (oh[i])
                idx = ID_WIDTH'(i);
        return idx;
    endfunction

    function automatic logic [ID_WIDTH-1:0] ptr_after(input logic [ID_WIDTH-1:0] idx);
        return (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        wr_gnt_c = rst ? '0 : rr_pick(bus.wr_req, wr_ptr);
        rd_gnt_c = rst ? '0 : rr_pick(bus.rd_req, rd_ptr);
        wr_idx   = onehot_idx(wr_gnt_c);
        rd_idx   = onehot_idx(rd_gnt_c);
    end

    always_comb begin
        waddr_c = '0;
        wdata_c = '0;
        raddr_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt_c[i]) begin
                waddr_c = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_c = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt_c[i])
                raddr_c = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        bus.wr_gnt     = wr_gnt_c;
        bus.rd_gnt     = rd_gnt_c;
        bus.bram_we    = |wr_gnt_c;
        bus.bram_waddr = waddr_c;
        bus.bram_wdata = wdata_c;
        bus.bram_re    = |rd_gnt_c;
        bus.bram_raddr = raddr_c;
        // Gated so a read granted just before reset never surfaces as valid.
        bus.rd_valid   = rd_valid_q & ~rst;
        bus.rd_id      = rd_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            if (|wr_gnt_c)
                wr_ptr <= ptr_after(wr_idx);
            if (|rd_gnt_c) begin
                rd_ptr  <= ptr_after(rd_idx);
                rd_id_q <= rd_idx;
            end
            rd_valid_q <= |rd_gnt_c;
        end
    end

`ifdef BRAM_RR_ARBITER_WR_BYPASS_EN
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= (|wr_gnt_c) & (|rd_gnt_c) & (waddr_c == raddr_c);
            byp_data_q <= wdata_c;
        end
    end

    always_comb bus.rd_data = byp_q ? byp_data_q : bus.bram_rdata;
`else
    always_comb bus.rd_data = bus.bram_rdata;
`endif

endmodule
